// File: rtl/stepper_move_seq_pkg.sv
// Shared types for the stepper move sequencer: FSM states, count width,
// and a saturating increment used by the step counter.
package stepper_move_seq_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    ENABLE,
    SETUP,
    STEP_HI,
    STEP_LO
  } state_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/limit_sync.sv
// Two-flop synchronizer for asynchronous limit sensor inputs; clears on reset.
module limit_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepper_move_seq.sv
// Stepper move sequencer: enable lead-in, direction setup, fixed-width STEP
// pulses at a clamped period, limit/abort handling and an idle enable timeout.
module stepper_move_seq
  import stepper_move_seq_pkg::*;
#(
  parameter int PULSE_W   = 50,
  parameter int EN_LEAD   = 100,
  parameter int DIR_SETUP = 10,
  parameter int EN_HOLD   = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_STEPS,
  input  logic [CNT_W-1:0] CMD_PERIOD,
  input  logic             LIMIT_FWD,
  input  logic             LIMIT_REV,
  input  logic             ABORT,
  output logic             STEP,
  output logic             DIR,
  output logic             EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAULT,
  output logic [CNT_W-1:0] STEPS_DONE
);

  localparam cnt_t PW_M1    = cnt_t'(PULSE_W - 1);
  localparam cnt_t PW_P1    = cnt_t'(PULSE_W + 1);
  localparam cnt_t LEAD_M1  = cnt_t'(EN_LEAD - 1);
  localparam cnt_t SETUP_M1 = cnt_t'(DIR_SETUP - 1);
  localparam cnt_t HOLD_M1  = cnt_t'(EN_HOLD - 1);

  state_t     state;
  cnt_t       cnt, idle_cnt, steps_tgt, period, steps_done;
  logic       step_r, dir_r, en_r, done_r, fault_r, abort_pend;
  logic [1:0] lim_s;
  logic       lim_block, seq_end;
  cnt_t       per_eff, lo_last;

  limit_sync #(.WIDTH(2)) u_limit_sync (
    .CLK (CLK),
    .RST (RST),
    .d   ({LIMIT_FWD, LIMIT_REV}),
    .q   (lim_s)
  );

  // Period is clamped so the low phase is always at least one cycle.
  assign per_eff   = (CMD_PERIOD > PW_P1) ? CMD_PERIOD : PW_P1;
  assign lo_last   = period - PW_P1;
  assign lim_block = dir_r ? lim_s[1] : lim_s[0];
  assign seq_end   = (state == SETUP) ? (cnt == SETUP_M1) : (cnt == lo_last);

  assign CMD_READY  = (state == IDLE);
  assign BUSY       = (state != IDLE);
  assign STEP       = step_r;
  assign DIR        = dir_r;
  assign EN         = en_r;
  assign DONE       = done_r;
  assign FAULT      = fault_r;
  assign STEPS_DONE = steps_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      idle_cnt   <= '0;
      steps_tgt  <= '0;
      period     <= '0;
      steps_done <= '0;
      step_r     <= 1'b0;
      dir_r      <= 1'b0;
      en_r       <= 1'b0;
      done_r     <= 1'b0;
      fault_r    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            dir_r      <= CMD_DIR;
            steps_tgt  <= CMD_STEPS;
            period     <= per_eff;
            steps_done <= '0;
            fault_r    <= 1'b0;
            idle_cnt   <= '0;
            cnt        <= '0;
            abort_pend <= 1'b0;
            if (CMD_STEPS == '0) begin
              done_r <= 1'b1;
            end else if (en_r) begin
              state <= SETUP;
            end else begin
              state <= ENABLE;
              en_r  <= 1'b1;
            end
          end else if (en_r) begin
            if (idle_cnt == HOLD_M1) begin
              en_r     <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + cnt_t'(1);
            end
          end
        end

        ENABLE: begin
          if (ABORT) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end else if (cnt == LEAD_M1) begin
            state <= SETUP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        // Both phases end in an attempt to enter STEP_HI; the limit is
        // checked only at that boundary and takes priority over ABORT.
        SETUP, STEP_LO: begin
          if (seq_end && lim_block) begin
            state   <= IDLE;
            fault_r <= 1'b1;
            done_r  <= 1'b1;
          end else if (ABORT) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end else if (seq_end) begin
            state      <= STEP_HI;
            step_r     <= 1'b1;
            cnt        <= '0;
            steps_done <= sat_inc(steps_done);
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        // ABORT here is deferred until the pulse completes.
        STEP_HI: begin
          if (ABORT) abort_pend <= 1'b1;
          if (cnt == PW_M1) begin
            step_r <= 1'b0;
            cnt    <= '0;
            if (steps_done == steps_tgt || abort_pend || ABORT) begin
              state  <= IDLE;
              done_r <= 1'b1;
            end else begin
              state <= STEP_LO;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        default: begin
          state  <= IDLE;
          step_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
